// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial CLA adder controller.
package cla_seq_pkg;

  // Width of the shared carry-lookahead adder slice.
  localparam int NIBBLE_W = 4;

  // Controller states: waiting for operands, stepping nibbles, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : cla_seq_pkg

// File: rtl/carry_lookahead_adder.sv
// 4-bit carry-lookahead adder: all nibble carries come from generate/propagate
// terms in parallel instead of rippling bit by bit.
module carry_lookahead_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] SUM,
  output logic       COUT
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = A ^ B;
  assign g = A & B;

  // Each carry is expanded directly from the generate/propagate terms below it.
  assign c[0] = CIN;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign SUM  = p ^ c[3:0];
  assign COUT = c[4];

endmodule : carry_lookahead_adder

// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit adder built by stepping one shared 4-bit CLA across the operands,
// least significant nibble first, with the carry held in a register between
// steps. Operands and results move through valid/ready handshakes.
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  // Operand width must split evenly into whole nibbles.
  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_width_check
    $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   idx;
  logic               carry_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic                accept;
  logic                last_nib;

  // The shared slice always sees the nibble currently selected by idx.
  assign nib_a    = a_reg[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b    = b_reg[idx*NIBBLE_W +: NIBBLE_W];
  assign accept   = in_valid && in_ready;
  assign last_nib = (idx == LAST_IDX);

  carry_lookahead_adder u_cla (
    .A    (nib_a),
    .B    (nib_b),
    .CIN  (carry_reg),
    .SUM  (nib_sum),
    .COUT (nib_cout)
  );

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_nib) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand capture, nibble stepping and result assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            sum       <= '0;
            cout      <= 1'b0;
            idx       <= '0;
          end
        end
        RUN: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_sum;
          carry_reg                     <= nib_cout;
          if (last_nib) begin
            cout <= nib_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Result is held untouched until the consumer takes it.
          if (out_ready) begin
            idx <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : cla_seq_adder_ctrl
